// File: rtl/hwpe_ctrl_uloop_seq_if.sv
// Bus bundle of the uloop sequencer: control inputs from the register file,
// uloop ctrl/flags and the job descriptor handshake towards the streamers.
interface hwpe_ctrl_uloop_seq_if #(
  parameter int unsigned NB_REG     = 4,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned NB_LOOPS   = 6,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 32
);
  // register file side
  logic                                 clear_i;
  logic                                 start_i;
  logic [NB_REG-1:0][ADDR_WIDTH-1:0]    base_addr_i;
  // uloop side
  logic                                 uloop_clear_o;
  logic                                 uloop_enable_o;
  logic                                 uloop_ready_o;
  logic                                 uloop_valid_i;
  logic                                 uloop_done_i;
  logic [NB_REG-1:0][REG_WIDTH-1:0]     uloop_offs_i;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   uloop_idx_i;
  // job descriptor side
  logic                                 job_valid_o;
  logic                                 job_ready_i;
  logic [NB_REG-1:0][ADDR_WIDTH-1:0]    job_addr_o;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   job_idx_o;
  logic                                 job_last_o;
  // status
  logic                                 busy_o;
  logic                                 done_o;
  logic [31:0]                          job_count_o;
  logic                                 err_o;

  // sequencer view
  modport master (
    input  clear_i, start_i, base_addr_i,
           uloop_valid_i, uloop_done_i, uloop_offs_i, uloop_idx_i,
           job_ready_i,
    output uloop_clear_o, uloop_enable_o, uloop_ready_o,
           job_valid_o, job_addr_o, job_idx_o, job_last_o,
           busy_o, done_o, job_count_o, err_o
  );

  // environment view (register file + uloop + job consumer)
  modport slave (
    output clear_i, start_i, base_addr_i,
           uloop_valid_i, uloop_done_i, uloop_offs_i, uloop_idx_i,
           job_ready_i,
    input  uloop_clear_o, uloop_enable_o, uloop_ready_o,
           job_valid_o, job_addr_o, job_idx_o, job_last_o,
           busy_o, done_o, job_count_o, err_o
  );
endinterface

// File: rtl/hwpe_ctrl_uloop_seq.sv
// Initiator-side uloop sequencer: starts the uloop, requests one iteration at
// a time and turns each offset set into a job descriptor (addr = base + offs).

// Per-lane address generator: base plus offset resized to the address width.
module hwpe_ctrl_uloop_seq_lane #(
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [REG_WIDTH-1:0]  offs_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);
  logic [ADDR_WIDTH-1:0] offs_ext;

  if (REG_WIDTH >= ADDR_WIDTH) begin : g_trunc
    assign offs_ext = offs_i[ADDR_WIDTH-1:0];
  end else begin : g_zext
    assign offs_ext = {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, offs_i};
  end

  // sum wraps modulo 2^ADDR_WIDTH
  assign addr_o = base_i + offs_ext;
endmodule

module hwpe_ctrl_uloop_seq #(
  parameter int unsigned NB_REG     = 4,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned NB_LOOPS   = 6,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  hwpe_ctrl_uloop_seq_if.master bus
);
  typedef logic [NB_REG-1:0][ADDR_WIDTH-1:0]  addr_t;
  typedef logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] idx_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_REQ, S_WAIT, S_FINISH
  } state_e;

  state_e      state_d, state_q;
  addr_t       base_d, base_q;
  addr_t       addr_d, addr_q;
  idx_t        idx_d, idx_q;
  logic        last_d, last_q;
  logic [31:0] cnt_d, cnt_q;
  logic        err_d, err_q;
  // registered outputs, decoded from the next state
  logic        busy_d, busy_q;
  logic        job_valid_d, job_valid_q;
  logic        enable_d, enable_q;
  logic        uclear_d, uclear_q;
  logic        done_d, done_q;

  addr_t       lane_addr;

  for (genvar g = 0; g < NB_REG; g++) begin : g_lane
    hwpe_ctrl_uloop_seq_lane #(
      .REG_WIDTH  (REG_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) i_lane (
      .base_i (base_q[g]),
      .offs_i (bus.uloop_offs_i[g]),
      .addr_o (lane_addr[g])
    );
  end

  // next-state, captured job fields, counters and output decode
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          base_d  = bus.base_addr_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // first job needs no uloop iteration: it sits at the bases
        addr_d  = base_q;
        idx_d   = '0;
        last_d  = 1'b0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.job_ready_i) begin
          if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
          state_d = last_q ? S_FINISH : S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.uloop_valid_i) begin
          addr_d  = lane_addr;
          idx_d   = bus.uloop_idx_i;
          last_d  = bus.uloop_done_i;
          state_d = S_ISSUE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // a response nobody asked for is dropped but remembered
    if (bus.uloop_valid_i && (state_q != S_WAIT)) err_d = 1'b1;

    if (bus.clear_i) begin
      state_d = S_IDLE;
      base_d  = '0;
      addr_d  = '0;
      idx_d   = '0;
      last_d  = 1'b0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end

    busy_d      = (state_d != S_IDLE);
    job_valid_d = (state_d == S_ISSUE);
    enable_d    = (state_d == S_REQ);
    uclear_d    = (state_d == S_CLEAR);
    done_d      = (state_d == S_FINISH);
  end

  // state and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      job_valid_q <= 1'b0;
      enable_q    <= 1'b0;
      uclear_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      job_valid_q <= job_valid_d;
      enable_q    <= enable_d;
      uclear_q    <= uclear_d;
      done_q      <= done_d;
    end
  end

  // soft clear is forwarded to the uloop in the same cycle
  assign bus.uloop_clear_o  = uclear_q | bus.clear_i;
  assign bus.uloop_enable_o = enable_q;
  assign bus.uloop_ready_o  = busy_q;
  assign bus.job_valid_o    = job_valid_q;
  assign bus.job_addr_o     = addr_q;
  assign bus.job_idx_o      = idx_q;
  assign bus.job_last_o     = last_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.job_count_o    = cnt_q;
  assign bus.err_o          = err_q;
endmodule
